rx_sample_framer: RTL and testbench

- Front-end stage of the receiver capture path. Sits between the DDC I/Q sample stream and the BRAM write interface block.
- On each transmit-pulse trigger, skips a programmable number of input samples (range gate delay) and then decimates the stream.
- Packs each kept sample into one 32-bit word {I,Q} and emits exactly N words as single-cycle valid/datos pulses. The downstream BRAM writer consumes these pulses.
- Tracks words lost while the downstream block is busy reading out.

---
 rtl/rx_sample_framer.sv | 126 ++++++++++++
 tb/tb_rx_sample_framer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_sample_framer.sv
// Receive capture front end: range-gate delay, decimation and
// {I,Q} word framing toward the BRAM writer.
module rx_sample_framer #(
  parameter int DEC_W = 16,
  parameter int OVF_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      delay_cfg,
  input  logic [31:0]      nsamp_cfg,
  input  logic [DEC_W-1:0] dec_cfg,
  input  logic             in_valid,
  input  logic [15:0]      in_i,
  input  logic [15:0]      in_q,
  input  logic             busy_in,
  output logic             valid,
  output logic [31:0]      datos,
  output logic             active,
  output logic             done,
  output logic [OVF_W-1:0] ovf_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    CAPTURE,
    DONE
  } state_t;

  state_t           state;
  logic [31:0]      delay_r;
  logic [31:0]      nsamp_r;
  logic [DEC_W-1:0] dec_r;
  logic [31:0]      dly_cnt;
  logic [31:0]      word_cnt;
  logic [DEC_W-1:0] phase;

  logic             last_dly;
  logic             last_word;
  logic             last_phase;
  logic             ovf_full;

  assign last_dly   = (dly_cnt + 32'd1) == delay_r;
  assign last_word  = (word_cnt + 32'd1) == nsamp_r;
  assign last_phase = phase == (dec_r - DEC_W'(1));
  assign ovf_full   = ovf_cnt == {OVF_W{1'b1}};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      valid    <= 1'b0;
      datos    <= '0;
      active   <= 1'b0;
      done     <= 1'b0;
      ovf_cnt  <= '0;
      delay_r  <= '0;
      nsamp_r  <= '0;
      dec_r    <= '0;
      dly_cnt  <= '0;
      word_cnt <= '0;
      phase    <= '0;
    end else begin
      valid <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            delay_r  <= delay_cfg;
            nsamp_r  <= nsamp_cfg;
            dec_r    <= (dec_cfg == '0) ? DEC_W'(1) : dec_cfg;
            dly_cnt  <= '0;
            word_cnt <= '0;
            phase    <= '0;
            ovf_cnt  <= '0;
            if (nsamp_cfg == 32'd0) begin
              state  <= DONE;
              active <= 1'b0;
            end else if (delay_cfg == 32'd0) begin
              state  <= CAPTURE;
              active <= 1'b1;
            end else begin
              state  <= DELAY;
              active <= 1'b1;
            end
          end
        end
        DELAY: begin
          // the delay-th sample is swallowed here, not captured
          if (in_valid) begin
            if (last_dly) begin
              state <= CAPTURE;
              phase <= '0;
            end else begin
              dly_cnt <= dly_cnt + 32'd1;
            end
          end
        end
        CAPTURE: begin
          if (in_valid) begin
            phase <= last_phase ? '0 : phase + DEC_W'(1);
            if (phase == '0) begin
              // dropped words still count so the window length is fixed
              word_cnt <= word_cnt + 32'd1;
              if (!busy_in) begin
                valid <= 1'b1;
                datos <= {in_i, in_q};
              end else if (!ovf_full) begin
                ovf_cnt <= ovf_cnt + OVF_W'(1);
              end
              if (last_word) begin
                state  <= DONE;
                active <= 1'b0;
              end
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_sample_framer.sv
// Directed bench for rx_sample_framer with immediate
// assertions at every check point.
module tb_rx_sample_framer;

  localparam int DEC_W = 16;
  localparam int OVF_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      delay_cfg = '0;
  logic [31:0]      nsamp_cfg = '0;
  logic [DEC_W-1:0] dec_cfg = '0;
  logic             in_valid = 1'b0;
  logic [15:0]      in_i = '0;
  logic [15:0]      in_q = '0;
  logic             busy_in = 1'b0;
  logic             valid;
  logic [31:0]      datos;
  logic             active;
  logic             done;
  logic [OVF_W-1:0] ovf_cnt;

  int tests = 0;
  int fails = 0;
  int npulse;

  always #5 clk = ~clk;

  rx_sample_framer #(
    .DEC_W(DEC_W),
    .OVF_W(OVF_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .delay_cfg(delay_cfg),
    .nsamp_cfg(nsamp_cfg),
    .dec_cfg  (dec_cfg),
    .in_valid (in_valid),
    .in_i     (in_i),
    .in_q     (in_q),
    .busy_in  (busy_in),
    .valid    (valid),
    .datos    (datos),
    .active   (active),
    .done     (done),
    .ovf_cnt  (ovf_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // drive one cycle of input, then look 1ns past the edge
  task automatic step(input logic iv, input logic [15:0] k);
    in_valid = iv;
    in_i = k;
    in_q = ~k;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic kick(input logic [31:0] d,
                      input logic [31:0] n,
                      input logic [DEC_W-1:0] dc);
    delay_cfg = d;
    nsamp_cfg = n;
    dec_cfg = dc;
    start = 1'b1;
    step(1'b0, 16'd0);
    delay_cfg = 32'd77;
    nsamp_cfg = 32'd1;
    dec_cfg = 16'd9;
  endtask

  task automatic expect_out(input string tag,
                            input logic ev,
                            input logic [15:0] k);
    chk({tag, "_valid"}, valid, ev);
    if (ev) chk({tag, "_datos"}, datos, {k, ~k});
  endtask

  initial begin
    // reset held while start/in_valid toggle
    rst = 1'b0;
    start = 1'b1;
    in_valid = 1'b1;
    nsamp_cfg = 32'd5;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("rst_valid", valid, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_active", active, 1'b0);
      chk("rst_ovf", ovf_cnt, 0);
      chk("rst_datos", datos, 0);
    end
    start = 1'b0;
    rst = 1'b1;
    step(1'b0, 16'd0);
    chk("idle_active", active, 1'b0);

    // basic window: delay 4, 8 words, no decimation
    kick(32'd4, 32'd8, 16'd1);
    chk("basic_active0", active, 1'b1);
    npulse = 0;
    for (int k = 0; k <= 12; k++) begin
      step(1'b1, 16'(k));
      expect_out("basic", k >= 4 && k <= 11, 16'(k));
      chk("basic_done", done, k == 12);
      chk("basic_active", active, k < 11);
      npulse += int'(valid);
    end
    step(1'b0, 16'd0);
    chk("basic_done_clr", done, 1'b0);
    chk("basic_npulse", npulse, 8);

    // dec 0 behaves as 1, samples every other cycle
    kick(32'd0, 32'd3, 16'd0);
    for (int k = 0; k <= 3; k++) begin
      step(1'b1, 16'(k));
      expect_out("dec0", k < 3, 16'(k));
      chk("dec0_done_a", done, 1'b0);
      step(1'b0, 16'd0);
      chk("dec0_gap_valid", valid, 1'b0);
      chk("dec0_done_b", done, k == 2);
    end

    // dec 3: keeps samples 0, 3, 6
    kick(32'd0, 32'd3, 16'd3);
    for (int k = 0; k <= 9; k++) begin
      step(1'b1, 16'(k));
      expect_out("dec3", k == 0 || k == 3 || k == 6, 16'(k));
      step(1'b0, 16'd0);
      chk("dec3_gap_valid", valid, 1'b0);
      chk("dec3_done", done, k == 6);
    end

    // backpressure on words 2 and 3
    kick(32'd0, 32'd6, 16'd1);
    for (int k = 0; k <= 6; k++) begin
      busy_in = (k == 2 || k == 3);
      step(1'b1, 16'(k));
      expect_out("bp", k == 0 || k == 1 || k == 4 || k == 5,
                 16'(k));
      if (k == 2 || k == 3)
        chk("bp_hold", datos, {16'd1, ~16'd1});
      chk("bp_ovf", ovf_cnt, (k < 2) ? 0 : (k == 2) ? 1 : 2);
      chk("bp_done", done, k == 6);
    end
    busy_in = 1'b0;
    step(1'b0, 16'd0);
    chk("bp_ovf_hold", ovf_cnt, 2);

    // new start clears ovf; a second start mid-capture is ignored
    kick(32'd0, 32'd4, 16'd1);
    chk("restart_ovf", ovf_cnt, 0);
    for (int k = 0; k <= 4; k++) begin
      if (k == 2) begin
        start = 1'b1;
        delay_cfg = 32'd5;
        nsamp_cfg = 32'd1;
      end
      step(1'b1, 16'(k));
      expect_out("ign", k < 4, 16'(k));
      chk("ign_done", done, k == 4);
    end

    // nsamp 0: done two cycles after start, no words
    kick(32'd0, 32'd0, 16'd1);
    chk("n0_done_a", done, 1'b0);
    chk("n0_active", active, 1'b0);
    step(1'b1, 16'd0);
    chk("n0_done_b", done, 1'b1);
    chk("n0_valid_b", valid, 1'b0);
    step(1'b1, 16'd1);
    chk("n0_done_c", done, 1'b0);
    chk("n0_valid_c", valid, 1'b0);

    // reset mid-capture aborts silently
    kick(32'd0, 32'd10, 16'd1);
    busy_in = 1'b1;
    step(1'b1, 16'd0);
    step(1'b1, 16'd1);
    chk("mid_ovf", ovf_cnt, 2);
    busy_in = 1'b0;
    step(1'b1, 16'd2);
    expect_out("mid", 1'b1, 16'd2);
    rst = 1'b0;
    step(1'b1, 16'd3);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_active", active, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_ovf", ovf_cnt, 0);
    chk("mid_rst_datos", datos, 0);
    rst = 1'b1;
    for (int k = 4; k <= 6; k++) begin
      step(1'b1, 16'(k));
      chk("post_valid", valid, 1'b0);
      chk("post_done", done, 1'b0);
      chk("post_active", active, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
